// File: rtl/game_session_ctrl.sv
// rtl/game_session_ctrl.sv - session sequencer for the note-memory game datapath
module game_session_ctrl #(
    parameter int          LIVES      = 3,
    parameter int          RST_CYCLES = 4,
    parameter int          ARM_CYCLES = 2,
    parameter int          TICK_DIV   = 5000000,
    parameter logic [31:0] LFSR_TAPS  = 32'h80200003
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_btn,
    input  logic        miss,
    input  logic        game_end,
    output logic        game_reset,
    output logic [31:0] data_out,
    output logic        write_enable,
    output logic        game_start,
    output logic [3:0]  lives,
    output logic [7:0]  miss_count,
    output logic [7:0]  elapsed,
    output logic [2:0]  state_out,
    output logic        busy
);

    localparam int CMAX = (RST_CYCLES > ARM_CYCLES) ? RST_CYCLES : ARM_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int TW   = $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_ARM   = 3'd3,
        S_START = 3'd4,
        S_PLAY  = 3'd5,
        S_WIN   = 3'd6,
        S_LOSE  = 3'd7
    } state_t;

    state_t        state;
    logic [31:0]   lfsr;
    logic [31:0]   pattern;
    logic          start_q;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tick;
    logic          start_edge;

    assign start_edge = start_btn && !start_q;
    assign state_out  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            lfsr         <= 32'h1;
            pattern      <= 32'h0;
            start_q      <= 1'b0;
            cnt          <= '0;
            tick         <= '0;
            game_reset   <= 1'b0;
            data_out     <= 32'h0;
            write_enable <= 1'b0;
            game_start   <= 1'b0;
            lives        <= 4'(LIVES);
            miss_count   <= 8'h0;
            elapsed      <= 8'h0;
            busy         <= 1'b0;
        end else begin
            // Free-running so the pattern depends on when the player presses start
            if (lfsr == 32'h0)
                lfsr <= 32'h1;
            else if (lfsr[0])
                lfsr <= (lfsr >> 1) ^ LFSR_TAPS;
            else
                lfsr <= lfsr >> 1;
            start_q      <= start_btn;
            game_reset   <= 1'b0;
            write_enable <= 1'b0;
            game_start   <= 1'b0;

            case (state)
                S_IDLE, S_WIN, S_LOSE: begin
                    if (start_edge) begin
                        state      <= S_CLR;
                        pattern    <= lfsr & 32'h7777_7777;
                        lives      <= 4'(LIVES);
                        miss_count <= 8'h0;
                        elapsed    <= 8'h0;
                        tick       <= '0;
                        cnt        <= '0;
                        game_reset <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_CLR: begin
                    if (cnt == CW'(RST_CYCLES - 1)) begin
                        state        <= S_LOAD;
                        cnt          <= '0;
                        write_enable <= 1'b1;
                        data_out     <= pattern;
                    end else begin
                        cnt        <= cnt + 1'b1;
                        game_reset <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_ARM;
                    cnt   <= '0;
                end
                S_ARM: begin
                    if (cnt == CW'(ARM_CYCLES - 1)) begin
                        state      <= S_START;
                        game_start <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: state <= S_PLAY;
                S_PLAY: begin
                    if (tick == TW'(TICK_DIV - 1)) begin
                        tick <= '0;
                        if (elapsed != 8'hFF)
                            elapsed <= elapsed + 8'd1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                    // A simultaneous miss is dropped: clearing the last note wins
                    if (game_end) begin
                        state      <= S_WIN;
                        game_reset <= 1'b1;
                        busy       <= 1'b0;
                    end else if (miss) begin
                        if (miss_count != 8'hFF)
                            miss_count <= miss_count + 8'd1;
                        lives <= lives - 4'd1;
                        if (lives == 4'd1) begin
                            state      <= S_LOSE;
                            game_reset <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_session_ctrl.sv
// tb/tb_game_session_ctrl.sv - randomized bench for game_session_ctrl against a timeline model
module tb_game_session_ctrl;

    localparam int          LIVES = 3;
    localparam int          RSTC  = 4;
    localparam int          ARMC  = 2;
    localparam int          TDIV  = 10;
    localparam logic [31:0] TAPS  = 32'h80200003;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start_btn = 1'b0;
    logic        miss = 1'b0;
    logic        game_end = 1'b0;
    logic        game_reset;
    logic [31:0] data_out;
    logic        write_enable;
    logic        game_start;
    logic [3:0]  lives;
    logic [7:0]  miss_count;
    logic [7:0]  elapsed;
    logic [2:0]  state_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // model: current session phase (numbered as on state_out) and how many cycles spent in it
    int          m_state, m_age, m_lives, m_miss, m_elapsed, m_tick;
    logic [31:0] m_lfsr, m_pattern, m_data;
    logic        m_prev;

    game_session_ctrl #(
        .LIVES(LIVES), .RST_CYCLES(RSTC), .ARM_CYCLES(ARMC), .TICK_DIV(TDIV), .LFSR_TAPS(TAPS)
    ) u_dut (
        .clk(clk), .reset(reset), .start_btn(start_btn), .miss(miss), .game_end(game_end),
        .game_reset(game_reset), .data_out(data_out), .write_enable(write_enable),
        .game_start(game_start), .lives(lives), .miss_count(miss_count), .elapsed(elapsed),
        .state_out(state_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_age = 1; m_lives = LIVES; m_miss = 0; m_elapsed = 0; m_tick = 0;
        m_lfsr = 32'h1; m_pattern = 32'h0; m_data = 32'h0; m_prev = 1'b0;
    endtask

    task automatic model_step();
        int  ns;
        logic edge_seen;
        edge_seen = start_btn && !m_prev;
        m_prev = start_btn;
        ns = m_state;
        if (m_state == 0 || m_state == 6 || m_state == 7) begin
            if (edge_seen) begin
                ns = 1; m_pattern = m_lfsr & 32'h7777_7777;
                m_lives = LIVES; m_miss = 0; m_elapsed = 0; m_tick = 0;
            end
        end else if (m_state == 1) begin
            if (m_age == RSTC) ns = 2;
        end else if (m_state == 2) begin
            ns = 3;
        end else if (m_state == 3) begin
            if (m_age == ARMC) ns = 4;
        end else if (m_state == 4) begin
            ns = 5;
        end else begin
            m_tick++;
            if (m_tick == TDIV) begin
                m_tick = 0;
                m_elapsed = (m_elapsed < 255) ? m_elapsed + 1 : 255;
            end
            if (game_end) ns = 6;
            else if (miss) begin
                m_miss = (m_miss < 255) ? m_miss + 1 : 255;
                m_lives--;
                if (m_lives == 0) ns = 7;
            end
        end
        if (ns == 2) m_data = m_pattern;
        if (m_lfsr == 0) m_lfsr = 32'h1;
        else if (m_lfsr[0]) m_lfsr = (m_lfsr >> 1) ^ TAPS;
        else m_lfsr = m_lfsr >> 1;
        m_age = (ns != m_state) ? 1 : m_age + 1;
        m_state = ns;
    endtask

    task automatic compare_all();
        expect_eq("state", 32'(state_out), 32'(m_state));
        expect_eq("lives", 32'(lives), 32'(m_lives));
        expect_eq("miss_count", 32'(miss_count), 32'(m_miss));
        expect_eq("elapsed", 32'(elapsed), 32'(m_elapsed));
        expect_eq("data_out", data_out, m_data);
        expect_eq("game_reset", 32'(game_reset),
                  32'((m_state == 1) || ((m_state == 6 || m_state == 7) && m_age == 1)));
        expect_eq("write_enable", 32'(write_enable), 32'(m_state == 2));
        expect_eq("game_start", 32'(game_start), 32'(m_state == 4));
        expect_eq("busy", 32'(busy), 32'(m_state >= 1 && m_state <= 5));
    endtask

    task automatic step(input logic s, input logic m, input logic g);
        start_btn = s; miss = m; game_end = g;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        compare_all();
        reset = 1'b1;
        step(0, 0, 0);
        expect_eq("lfsr_probe", u_dut.lfsr, 32'h80200003);

        // misses and game_end in IDLE are ignored
        step(0, 1, 0);
        step(0, 0, 1);

        // start, with a held button and a fresh edge during ARM
        step(1, 0, 0);
        repeat (4) step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        expect_eq("start_seq_start", 32'(game_start), 32'd1);
        step(0, 0, 0);
        expect_eq("start_seq_play", 32'(state_out), 32'd5);

        // lose path
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            expect_eq("lose_lives", 32'(lives), 32'(2 - i));
            if (i < 2) repeat (9) step(0, 0, 0);
        end
        expect_eq("lose_state", 32'(state_out), 32'd7);
        expect_eq("lose_misses", 32'(miss_count), 32'd3);
        expect_eq("lose_reset_pulse", 32'(game_reset), 32'd1);
        step(0, 0, 0);
        expect_eq("lose_reset_drop", 32'(game_reset), 32'd0);

        // restart from LOSE, then win with a tied miss
        step(1, 0, 0);
        repeat (8) step(0, 0, 0);
        repeat (35) step(0, 0, 0);
        step(0, 1, 1);
        expect_eq("tie_state", 32'(state_out), 32'd6);
        expect_eq("tie_lives", 32'(lives), 32'd3);
        expect_eq("tie_misses", 32'(miss_count), 32'd0);
        expect_eq("tie_elapsed", 32'(elapsed), 32'd3);

        // restart from WIN, async reset mid-PLAY
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);
        #2 reset = 1'b0;
        #1;
        expect_eq("async_state", 32'(state_out), 32'd0);
        expect_eq("async_strobes", 32'({game_reset, write_enable, game_start, busy}), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        compare_all();
        step(1, 0, 0);
        repeat (12) step(0, 0, 0);

        // randomized play
        for (int i = 0; i < 2500; i++) begin
            logic s;
            s = start_btn;
            if ($urandom_range(0, 24) == 0) s = ~s;
            step(s, $urandom_range(0, 7) == 0, $urandom_range(0, 59) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
